// File: rtl/pwm_capture_pkg.sv
// Shared constants and encodings for the PWM capture block.
package pwm_capture_pkg;

  // One second of silence at the 15.625 MHz divided clock.
  localparam int unsigned PWM_TIMEOUT_1S = 32'd15_625_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_FLAT = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for the asynchronous PWM input followed by a
// registered edge detector; edges appear three clocks after pwm_i moves.
module pwm_sync_edge (
  input  logic clk_div_i,
  input  logic rst_n_i,
  input  logic pwm_i,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk_div_i) begin
    if (!rst_n_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pwm_i;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
      fall  <= ~sync2 & sync3;
    end
  end

  // sync3 is aligned with the rise/fall flags.
  assign lvl = sync3;

endmodule

// File: rtl/pwm_capture.sv
// PWM measurement: recovers high/low time, period and brightness trend
// of an external PWM input, and flags an input that stops toggling.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = PWM_TIMEOUT_1S,
  parameter int unsigned TREND_TH = 4
) (
  input  logic             clk_div_i,
  input  logic             rst_n_i,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] low_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic [1:0]       dir_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned EXT_W = CNT_W + 2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [EXT_W-1:0] TH_EXT  = EXT_W'(TREND_TH);

  logic lvl;
  logic rise;
  logic fall;
  logic any_edge;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_nxt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] lcnt_nxt;
  logic [CNT_W-1:0] prev_high;
  logic [CNT_W-1:0] prev_nxt;
  logic [TO_W-1:0]  idle_cnt;
  logic [TO_W-1:0]  idle_nxt;
  logic             first;
  logic             first_nxt;
  logic             skip;
  logic             skip_nxt;

  logic [CNT_W-1:0] high_nxt;
  logic [CNT_W-1:0] low_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [1:0]       dir_nxt;
  logic             valid_nxt;
  logic             stuck_nxt;

  logic [CNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0] lcnt_inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] period_sat;
  logic [EXT_W-1:0] hcnt_ext;
  logic [EXT_W-1:0] prev_ext;
  dir_t             trend;

  pwm_sync_edge u_sync (
    .clk_div_i (clk_div_i),
    .rst_n_i   (rst_n_i),
    .pwm_i     (pwm_i),
    .lvl       (lvl),
    .rise      (rise),
    .fall      (fall)
  );

  assign any_edge = rise | fall;

  // Saturating counter increments and period sum.
  assign hcnt_inc   = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
  assign lcnt_inc   = (lcnt == CNT_MAX) ? lcnt : lcnt + CNT_ONE;
  assign sum        = {1'b0, hcnt} + {1'b0, lcnt};
  assign period_sat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

  // Trend compare in widened arithmetic so prev_high + TREND_TH cannot overflow.
  assign hcnt_ext = {2'b00, hcnt};
  assign prev_ext = {2'b00, prev_high};

  always_comb begin
    trend = DIR_FLAT;
    if (first) begin
      trend = DIR_FLAT;
    end else if (hcnt_ext >= prev_ext + TH_EXT) begin
      trend = DIR_UP;
    end else if (prev_ext >= hcnt_ext + TH_EXT) begin
      trend = DIR_DOWN;
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    lcnt_nxt   = lcnt;
    prev_nxt   = prev_high;
    first_nxt  = first;
    skip_nxt   = skip;
    high_nxt   = high_o;
    low_nxt    = low_o;
    period_nxt = period_o;
    dir_nxt    = dir_o;
    valid_nxt  = 1'b0;
    idle_nxt   = any_edge ? '0 :
                 ((idle_cnt == TO_LIM) ? idle_cnt : idle_cnt + TO_W'(1));

    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          hcnt_nxt  = CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_nxt = ST_LOW;
          lcnt_nxt  = CNT_ONE;
        end else begin
          hcnt_nxt = hcnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          // A LOW phase entered from STUCK has no trustworthy high time.
          if (!skip) begin
            high_nxt   = hcnt;
            low_nxt    = lcnt;
            period_nxt = period_sat;
            dir_nxt    = trend;
            prev_nxt   = hcnt;
            first_nxt  = 1'b0;
            valid_nxt  = 1'b1;
          end
          skip_nxt  = 1'b0;
          state_nxt = ST_HIGH;
          hcnt_nxt  = CNT_ONE;
        end else begin
          lcnt_nxt = lcnt_inc;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          hcnt_nxt  = CNT_ONE;
        end else if (fall) begin
          state_nxt = ST_LOW;
          lcnt_nxt  = CNT_ONE;
          skip_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Silence timeout overrides any state; the next valid restarts the trend.
    if (!any_edge && (idle_nxt == TO_LIM)) begin
      state_nxt = ST_STUCK;
      first_nxt = 1'b1;
      skip_nxt  = 1'b0;
      valid_nxt = 1'b0;
    end

    stuck_nxt = (state_nxt == ST_STUCK);
  end

  always_ff @(posedge clk_div_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      lcnt      <= '0;
      prev_high <= '0;
      idle_cnt  <= '0;
      first     <= 1'b1;
      skip      <= 1'b0;
      high_o    <= '0;
      low_o     <= '0;
      period_o  <= '0;
      dir_o     <= 2'b00;
      valid_o   <= 1'b0;
      stuck_o   <= 1'b0;
      level_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      lcnt      <= lcnt_nxt;
      prev_high <= prev_nxt;
      idle_cnt  <= idle_nxt;
      first     <= first_nxt;
      skip      <= skip_nxt;
      high_o    <= high_nxt;
      low_o     <= low_nxt;
      period_o  <= period_nxt;
      dir_o     <= dir_nxt;
      valid_o   <= valid_nxt;
      stuck_o   <= stuck_nxt;
      level_o   <= lvl;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives PWM periods of known length and
// compares reported measurements against an arithmetic model of the rules.
module tb_pwm_capture;

  localparam int TO = 1000;
  localparam int TH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pwm   = 1'b0;

  logic [31:0] high, low, period;
  logic        valid, stuck, level;
  logic [1:0]  dir;
  logic [7:0]  high8, low8, period8;
  logic        valid8, stuck8, level8;
  logic [1:0]  dir8;

  int    checks = 0;
  int    errors = 0;
  longint cyc   = 0;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(32), .TIMEOUT(TO), .TREND_TH(TH)) dut (
    .clk_div_i (clk),
    .rst_n_i   (rst_n),
    .pwm_i     (pwm),
    .high_o    (high),
    .low_o     (low),
    .period_o  (period),
    .valid_o   (valid),
    .dir_o     (dir),
    .stuck_o   (stuck),
    .level_o   (level)
  );

  pwm_capture #(.CNT_W(8), .TIMEOUT(TO), .TREND_TH(TH)) dut8 (
    .clk_div_i (clk),
    .rst_n_i   (rst_n),
    .pwm_i     (pwm),
    .high_o    (high8),
    .low_o     (low8),
    .period_o  (period8),
    .valid_o   (valid8),
    .dir_o     (dir8),
    .stuck_o   (stuck8),
    .level_o   (level8)
  );

  typedef struct {
    int         h;
    int         l;
    int         p;
    logic [1:0] d;
    longint     c;
  } rep_t;

  rep_t vq[$];
  rep_t vq8[$];
  rep_t exq[$];

  bit ref_first;
  int ref_prev;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every reported measurement away from the active edge.
  always @(negedge clk) begin
    if (valid)  vq.push_back('{h: int'(high), l: int'(low), p: int'(period), d: dir, c: cyc});
    if (valid8) vq8.push_back('{h: int'(high8), l: int'(low8), p: int'(period8), d: dir8, c: cyc});
    if (valid && stuck) begin
      errors++;
      $display("FAIL valid_stuck_overlap at cycle %0d", cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ref_first = 1'b1;
    ref_prev  = 0;
    exq.delete();
    vq.delete();
    vq8.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pwm   = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    model_reset();
  endtask

  // One rise-to-rise period; the model predicts what its report will contain.
  task automatic drive_period(input int h, input int l);
    rep_t e;
    int   diff;
    diff = h - ref_prev;
    e.h  = h;
    e.l  = l;
    e.p  = h + l;
    e.c  = 0;
    if (ref_first)          e.d = 2'b00;
    else if (diff >= TH)    e.d = 2'b01;
    else if (-diff >= TH)   e.d = 2'b10;
    else                    e.d = 2'b00;
    ref_first = 1'b0;
    ref_prev  = h;
    exq.push_back(e);
    pwm = 1'b1;
    wait_cyc(h);
    pwm = 1'b0;
    wait_cyc(l);
  endtask

  // Final rising edge closes the last period, then compare all reports.
  task automatic close_check(input string name);
    pwm = 1'b1;
    wait_cyc(8);
    checks++;
    if (vq.size() != exq.size()) begin
      errors++;
      $display("FAIL %s report_count got %0d want %0d", name, vq.size(), exq.size());
    end else begin
      foreach (exq[i]) begin
        checks++;
        if (vq[i].h !== exq[i].h || vq[i].l !== exq[i].l ||
            vq[i].p !== exq[i].p || vq[i].d !== exq[i].d) begin
          errors++;
          $display("FAIL %s report[%0d] got h=%0d l=%0d p=%0d dir=%0d want h=%0d l=%0d p=%0d dir=%0d",
                   name, i, vq[i].h, vq[i].l, vq[i].p, vq[i].d,
                   exq[i].h, exq[i].l, exq[i].p, exq[i].d);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pwm = ~pwm;
      wait_cyc(1);
    end
    checks++;
    if ({high, low, period, valid, dir, stuck, level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got h=%0h l=%0h p=%0h v=%b d=%b s=%b lv=%b want all 0",
               high, low, period, valid, dir, stuck, level);
    end
    checks++;
    if ({high8, low8, period8, valid8, dir8, stuck8, level8} !== '0) begin
      errors++;
      $display("FAIL reset_outputs8 got h=%0h l=%0h p=%0h v=%b want all 0",
               high8, low8, period8, valid8);
    end
    pwm = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    model_reset();
    wait_cyc(4);
    drive_period(7, 9);
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL reset_no_early_valid got %0d reports want 0", vq.size());
    end
    close_check("reset_first_period");
  endtask

  task automatic test_fixed();
    do_reset();
    wait_cyc(5);
    repeat (5) drive_period(30, 70);
    close_check("fixed_30_70");
    if (vq.size() == 5) begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (vq[i].c - vq[i-1].c != 100) begin
          errors++;
          $display("FAIL fixed_spacing[%0d] got %0d want 100", i, vq[i].c - vq[i-1].c);
        end
      end
    end
  endtask

  task automatic test_trend();
    int hs[6] = '{30, 40, 40, 35, 37, 30};
    do_reset();
    wait_cyc(5);
    foreach (hs[i]) drive_period(hs[i], 100 - hs[i]);
    close_check("trend");
  endtask

  task automatic test_random();
    do_reset();
    wait_cyc(5);
    for (int i = 0; i < 12; i++) begin
      drive_period(int'($urandom_range(2, 60)), int'($urandom_range(2, 60)));
    end
    close_check("random");
  endtask

  task automatic test_stuck();
    do_reset();
    wait_cyc(5);
    drive_period(20, 80);
    drive_period(20, 80);
    pwm = 1'b1;
    wait_cyc(TO);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_early got %b want 0", stuck);
    end
    wait_cyc(10);
    checks++;
    if (stuck !== 1'b1 || level !== 1'b1) begin
      errors++;
      $display("FAIL stuck_set got stuck=%b level=%b want 1 1", stuck, level);
    end
    pwm = 1'b0;
    wait_cyc(6);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clear got %b want 0", stuck);
    end
    wait_cyc(44);
    ref_first = 1'b1;
    drive_period(50, 50);
    drive_period(50, 50);
    close_check("stuck_resume");
  endtask

  task automatic test_sat();
    do_reset();
    wait_cyc(5);
    drive_period(300, 20);
    close_check("sat_wide");
    checks++;
    if (vq8.size() != 1) begin
      errors++;
      $display("FAIL sat8_count got %0d want 1", vq8.size());
    end else begin
      checks++;
      if (vq8[0].h !== 255 || vq8[0].l !== 20 || vq8[0].p !== 255 || vq8[0].d !== 2'b00) begin
        errors++;
        $display("FAIL sat8_fields got h=%0d l=%0d p=%0d d=%0d want h=255 l=20 p=255 d=0",
                 vq8[0].h, vq8[0].l, vq8[0].p, vq8[0].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_cyc(5);
    drive_period(40, 60);
    drive_period(40, 60);
    pwm = 1'b1;
    wait_cyc(40);
    pwm = 1'b0;
    wait_cyc(30);
    rst_n = 1'b0;
    wait_cyc(1);
    checks++;
    if ({high, low, period, valid, dir, stuck} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got h=%0d l=%0d p=%0d v=%b d=%b s=%b want all 0",
               high, low, period, valid, dir, stuck);
    end
    rst_n = 1'b1;
    model_reset();
    wait_cyc(10);
    drive_period(25, 75);
    close_check("reset_mid_restart");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_trend();
    test_random();
    test_stuck();
    test_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
